// File: rtl/fibo_datapath.sv
// Fibonacci datapath: 4-entry register file, single ALU, zero/overflow flags
// and a DONE edge detector that captures the result register with a valid strobe.
package fibo_pkg;
  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_DEC  = 3'b011,
    OP_INC  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_ZERO = 3'b111
  } alu_op_e;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_HELD = 1'b1
  } cap_state_e;
endpackage

module fibo_datapath
  import fibo_pkg::*;
#(
  parameter int         WIDTH       = 8,
  parameter logic [1:0] RESULT_ADDR = 2'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_opcode,
  input  logic [1:0]       rd_addr1,
  input  logic [1:0]       rd_addr2,
  input  logic [1:0]       wrt_addr,
  input  logic             wrt_en,
  input  logic             load_data,
  input  logic [WIDTH-1:0] data_in,
  input  logic             done,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic [WIDTH-1:0] fib_out,
  output logic             fib_valid
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [WIDTH-1:0] wr_data;
  alu_op_e          alu_op;

  cap_state_e cap_state;
  cap_state_e cap_state_nxt;
  logic       capture_en;

  // Combinational read ports; a same-cycle write is not forwarded, so a
  // read-during-write returns the old contents.
  assign op_a   = regs[rd_addr1];
  assign op_b   = regs[rd_addr2];
  assign alu_op = alu_op_e'(alu_opcode);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a value unassigned (latch).
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    unique case (alu_op)
      OP_PASS: alu_result = op_a;
      OP_ADD:  {alu_carry, alu_result} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  alu_result = op_a - op_b;
      OP_DEC:  alu_result = op_a - ONE;
      OP_INC:  alu_result = op_a + ONE;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_ZERO: alu_result = '0;
    endcase
  end

  assign wr_data = load_data ? data_in : alu_result;

  // NOTE: the register file is small and the FSM relies on known contents
  // after reset, so every entry is reset rather than left as plain memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wrt_en) begin
      // NOTE: non-blocking assignment keeps the old value visible to every
      // reader clocked on this same edge (including the result capture).
      regs[wrt_addr] <= wr_data;
    end
  end

  // Zero flag resets low so the controller never sees a spurious loop exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
    end else if (wrt_en) begin
      zero_flag <= (wr_data == '0);
    end
  end

  // Overflow is sticky across a computation; a load marks a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
    end else if (wrt_en && load_data) begin
      ovf_flag <= 1'b0;
    end else if (wrt_en && (alu_op == OP_ADD) && alu_carry) begin
      ovf_flag <= 1'b1;
    end
  end

  // DONE edge detector: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state <= CAP_IDLE;
    end else begin
      cap_state <= cap_state_nxt;
    end
  end

  // DONE edge detector: next-state logic.
  always_comb begin
    cap_state_nxt = cap_state;
    unique case (cap_state)
      CAP_IDLE: if (done)  cap_state_nxt = CAP_HELD;
      CAP_HELD: if (!done) cap_state_nxt = CAP_IDLE;
    endcase
  end

  // DONE edge detector: output decode.
  always_comb begin
    capture_en = 1'b0;
    unique case (cap_state)
      CAP_IDLE: capture_en = done;
      CAP_HELD: capture_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fib_out   <= '0;
      fib_valid <= 1'b0;
    end else begin
      fib_valid <= capture_en;
      if (capture_en) fib_out <= regs[RESULT_ADDR];
    end
  end

endmodule

// File: tb/tb_fibo_datapath.sv
// Directed self-checking bench for fibo_datapath; register contents are
// observed through the zero flag and through DONE captures of R2.
module tb_fibo_datapath;

  localparam int W = 8;

  localparam logic [2:0] PASS = 3'b000;
  localparam logic [2:0] ADD  = 3'b001;
  localparam logic [2:0] SUB  = 3'b010;
  localparam logic [2:0] DEC  = 3'b011;
  localparam logic [2:0] INC  = 3'b100;
  localparam logic [2:0] AND_ = 3'b101;
  localparam logic [2:0] OR_  = 3'b110;
  localparam logic [2:0] ZERO = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   alu_opcode;
  logic [1:0]   rd_addr1;
  logic [1:0]   rd_addr2;
  logic [1:0]   wrt_addr;
  logic         wrt_en;
  logic         load_data;
  logic [W-1:0] data_in;
  logic         done;
  logic         zero_flag;
  logic         ovf_flag;
  logic [W-1:0] fib_out;
  logic         fib_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fibo_datapath #(.WIDTH(W), .RESULT_ADDR(2'd2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_opcode (alu_opcode),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .wrt_addr   (wrt_addr),
    .wrt_en     (wrt_en),
    .load_data  (load_data),
    .data_in    (data_in),
    .done       (done),
    .zero_flag  (zero_flag),
    .ovf_flag   (ovf_flag),
    .fib_out    (fib_out),
    .fib_valid  (fib_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [1:0] dst, input logic [W-1:0] val);
    wrt_addr  = dst;
    data_in   = val;
    load_data = 1'b1;
    wrt_en    = 1'b1;
    tick();
    wrt_en    = 1'b0;
    load_data = 1'b0;
  endtask

  task automatic op(input logic [2:0] opc, input logic [1:0] a, input logic [1:0] b,
                    input logic [1:0] dst);
    alu_opcode = opc;
    rd_addr1   = a;
    rd_addr2   = b;
    wrt_addr   = dst;
    load_data  = 1'b0;
    wrt_en     = 1'b1;
    tick();
    wrt_en     = 1'b0;
  endtask

  // One DONE pulse: strobe and value one edge later, strobe gone the edge after.
  task automatic capture(input string tag, input logic [W-1:0] exp);
    done = 1'b1;
    tick();
    check({tag, "_valid"}, fib_valid, 1);
    check({tag, "_out"}, fib_out, exp);
    done = 1'b0;
    tick();
    check({tag, "_valid_drop"}, fib_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] m0, m1, m2, m3;
    int           iters;
    bit           found;

    rst_n = 1'b0; alu_opcode = PASS; rd_addr1 = 0; rd_addr2 = 0; wrt_addr = 0;
    wrt_en = 1'b0; load_data = 1'b0; data_in = '0; done = 1'b0;
    #3;
    check("rst_zero", zero_flag, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_fib_out", fib_out, 0);
    check("rst_fib_valid", fib_valid, 0);
    #9 rst_n = 1'b1;

    // Reset mid-computation: build up nonzero state, then reset between edges.
    ld(1, 8'd5);
    check("ld5_zero", zero_flag, 0);
    ld(0, 8'd255);
    op(ADD, 0, 1, 3);                 // 255+5 = 260 -> R3=4, carry
    check("pre_rst_ovf", ovf_flag, 1);
    check("pre_rst_zero", zero_flag, 0);
    ld(2, 8'd9);
    capture("pre_rst_cap", 8'd9);
    op(ZERO, 0, 0, 0);
    check("pre_rst_zero_op", zero_flag, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_zero", zero_flag, 0);
    check("midrst_ovf", ovf_flag, 0);
    check("midrst_fib_out", fib_out, 0);
    #2 rst_n = 1'b1;
    op(PASS, 1, 0, 0);                // R1 was 5 before reset
    check("rst_r1_cleared", zero_flag, 1);
    op(PASS, 3, 0, 0);                // R3 was 4 before reset
    check("rst_r3_cleared", zero_flag, 1);
    op(INC, 0, 0, 0);
    check("inc_nonzero", zero_flag, 0);

    // Load zero, DEC wraps to FF, INC wraps back to 0.
    ld(3, 8'd0);
    check("ld0_zero", zero_flag, 1);
    op(DEC, 3, 0, 3);
    check("dec_wrap_zero", zero_flag, 0);
    op(INC, 3, 0, 3);
    check("inc_wrap_zero", zero_flag, 1);
    op(PASS, 3, 0, 2);
    capture("dec_inc_cap", 8'd0);

    // LOAD_DATA without WRT_EN writes nothing and leaves the flag alone.
    ld(2, 8'd77);
    wrt_addr = 2; data_in = 8'd0; load_data = 1'b1; wrt_en = 1'b0;
    tick();
    load_data = 1'b0;
    check("load_no_we_zero", zero_flag, 0);
    capture("load_no_we_cap", 8'd77);

    // Logic/arith opcodes, results routed to R2 for capture.
    ld(0, 8'hF0);
    ld(1, 8'h3C);
    op(AND_, 0, 1, 2); capture("and", 8'h30);
    op(OR_, 0, 1, 2);  capture("or", 8'hFC);
    op(SUB, 0, 1, 2);  capture("sub", 8'hB4);
    op(SUB, 1, 1, 2);
    check("sub_self_zero", zero_flag, 1);

    // Fibonacci loop against a bench-side model of the same register moves.
    ld(0, 8'd0); ld(1, 8'd1); ld(3, 8'd6);
    m0 = 0; m1 = 1; m2 = 0; m3 = 6; iters = 0; found = 0;
    for (int it = 1; it <= 10 && !found; it++) begin
      op(ADD, 0, 1, 2);  m2 = m0 + m1;
      op(PASS, 1, 0, 0); m0 = m1;
      op(PASS, 2, 0, 1); m1 = m2;
      op(DEC, 3, 0, 3);  m3 = m3 - 1;
      check("fib_loop_zero", zero_flag, (m3 == 0));
      iters = it;
      if (zero_flag) found = 1;
    end
    check("fib_iters", iters, 6);
    check("fib_ovf", ovf_flag, 0);
    check("fib_model_r2", m2, 8'd13);

    // R2 now holds 13: DONE held four cycles yields a single strobe.
    done = 1'b1;
    tick();
    check("cap_hold_valid1", fib_valid, 1);
    check("cap_hold_out", fib_out, m2);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("cap_hold_valid_low", fib_valid, 0);
    end
    done = 1'b0;
    tick();
    check("cap_gap_valid", fib_valid, 0);
    done = 1'b1;
    tick();
    check("cap_re_valid", fib_valid, 1);
    check("cap_re_out", fib_out, 8'd13);
    done = 1'b0;
    tick();
    check("cap_re_drop", fib_valid, 0);
    check("cap_out_hold", fib_out, 8'd13);

    // Overflow: 200+100 = 300 -> 44 with carry; sticky until next load.
    ld(0, 8'd200);
    ld(1, 8'd100);
    op(ADD, 0, 1, 2);
    check("ovf_set", ovf_flag, 1);
    check("ovf_zero", zero_flag, 0);
    capture("ovf_cap", 8'd44);
    op(PASS, 0, 0, 3);
    check("ovf_sticky", ovf_flag, 1);
    ld(3, 8'd1);
    check("ovf_clear_on_load", ovf_flag, 0);

    // DONE rises on the same edge that writes R2: capture sees the old value.
    ld(2, 8'd13);
    done = 1'b1;
    ld(2, 8'd21);
    check("simul_valid", fib_valid, 1);
    check("simul_old", fib_out, 8'd13);
    done = 1'b0;
    tick();
    capture("simul_new", 8'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
